// File: rtl/md_defs.sv
// Shared multiply/divide definitions: op encodings, state type, default latencies.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled with `define MD_MADD_EN.
package md_defs;

`ifdef MD_MADD_EN
    localparam int unsigned MD_OP_W = 4;
`else
    localparam int unsigned MD_OP_W = 3;
`endif

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Declaration order fixes the encodings: MULT=0 .. MTLO=5, MADD..MSUBU=6..9.
    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MTHI,
        MD_MTLO
`ifdef MD_MADD_EN
        ,
        MD_MADD,
        MD_MADDU,
        MD_MSUB,
        MD_MSUBU
`endif
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing the next {HI,LO}.
// Accumulating ops are included when MD_MADD_EN is defined.
module md_compute
    import md_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]   i_src_a,
    input  logic [WIDTH-1:0]   i_src_b,
    input  logic [WIDTH-1:0]   i_hi,
    input  logic [WIDTH-1:0]   i_lo,
    output logic [WIDTH-1:0]   o_res_hi,
    output logic [WIDTH-1:0]   o_res_lo
);

    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_div_b;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;

    // Sign-extending to 2*WIDTH makes the modular unsigned product equal the signed one.
    assign w_prod_s = {{WIDTH{i_src_a[WIDTH-1]}}, i_src_a} * {{WIDTH{i_src_b[WIDTH-1]}}, i_src_b};
    assign w_prod_u = {{WIDTH{1'b0}}, i_src_a} * {{WIDTH{1'b0}}, i_src_b};

    assign w_neg_a  = i_src_a[WIDTH-1];
    assign w_neg_b  = i_src_b[WIDTH-1];
    assign w_b_zero = (i_src_b == '0);
    assign w_mag_a  = w_neg_a ? ('0 - i_src_a) : i_src_a;
    assign w_mag_b  = w_neg_b ? ('0 - i_src_b) : i_src_b;

    // Signed divide on magnitudes so MIN / -1 wraps to MIN instead of overflowing.
    assign w_div_b  = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    assign w_q_mag  = w_mag_a / w_div_b;
    assign w_r_mag  = w_mag_a % w_div_b;
    assign w_q_s    = (w_neg_a ^ w_neg_b) ? ('0 - w_q_mag) : w_q_mag;
    assign w_r_s    = w_neg_a ? ('0 - w_r_mag) : w_r_mag;
    assign w_q_u    = i_src_a / (w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_src_b);
    assign w_r_u    = i_src_a % (w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_src_b);

    always_comb begin
        o_res_hi = i_hi;
        o_res_lo = i_lo;
        case (i_op)
            MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
            MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
            MD_DIV: begin
                if (!w_b_zero) begin
                    o_res_hi = w_r_s;
                    o_res_lo = w_q_s;
                end
            end
            MD_DIVU: begin
                if (!w_b_zero) begin
                    o_res_hi = w_r_u;
                    o_res_lo = w_q_u;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_s;
            MD_MADDU: {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_u;
            MD_MSUB:  {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_s;
            MD_MSUBU: {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer owning HI/LO; raises md_stall for D-stage HI/LO ops.
// Define MD_MADD_EN to add MADD/MADDU/MSUB/MSUBU (4-bit md_op).
module md_sequencer
    import md_defs::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               D_is_md,
    output logic               busy,
    output logic               done,
    output logic               md_stall,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_is_mul;
    logic               w_is_div;

    md_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .i_op     (md_op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo)
    );

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: w_is_mul = 1'b1;
            MD_DIV, MD_DIVU:   w_is_div = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: w_is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_mul || w_is_div) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            r_done    <= w_is_div ? (DIV_CYCLES == 1) : (MULT_CYCLES == 1);
                            r_busy    <= 1'b1;
                            r_state   <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= src_a;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    // done is registered, so it is raised one edge ahead of the count reaching 1.
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_done <= (r_cnt == CNT_W'(2));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_stall = D_is_md & (start | r_busy);

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed cases plus randomized ops against a 64-bit model.
// Exercises MADD/MSUB ops as well when MD_MADD_EN is defined.
`timescale 1ns/1ps
module tb_md_sequencer;
    import md_defs::*;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;
    localparam int unsigned OPMAX = (1 << MD_OP_W) - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [MD_OP_W-1:0] md_op = '0;
    logic [31:0]        src_a = '0;
    logic [31:0]        src_b = '0;
    logic               D_is_md = 1'b0;
    logic               busy;
    logic               done;
    logic               md_stall;
    logic [31:0]        hi;
    logic [31:0]        lo;

    md_sequencer #(
        .WIDTH       (32),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .done     (done),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_hilo = '0;
    logic [63:0] mon_hilo = '0;
    int unsigned rem = 0;
    logic        commit_due = 1'b0;
    logic        mt_due = 1'b0;
    logic        hold_d = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned op_latency(input int unsigned op);
        case (op)
            0, 1: return NM;
            2, 3: return ND;
`ifdef MD_MADD_EN
            6, 7, 8, 9: return NM;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_model(input int unsigned op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        res = hl;
        case (op)
            0: res = sa * sb;
            1: res = ua * ub;
            2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            4: res = {a, hl[31:0]};
            5: res = {hl[63:32], a};
`ifdef MD_MADD_EN
            6: res = hl + sa * sb;
            7: res = hl + ua * ub;
            8: res = hl - sa * sb;
            9: res = hl - ua * ub;
`endif
            default: ;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: tracks expected busy window from observed starts; pops scoreboard on commit.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem        = 0;
            commit_due = 1'b0;
            mt_due     = 1'b0;
            mon_hilo   = '0;
            exp_q.delete();
        end else begin
            commit_due = 1'b0;
            mt_due     = 1'b0;
            if (rem > 0) begin
                check("no_start_in_run", start, 1'b0);
                rem--;
                if (rem == 0) commit_due = 1'b1;
            end else if (start) begin
                if (op_latency(md_op) > 0) rem = op_latency(md_op);
                else if (md_op == 4 || md_op == 5) mt_due = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (commit_due || mt_due) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: actual=commit required=no_commit at %0t", $time);
                end else begin
                    mon_hilo = exp_q.pop_front();
                end
            end
            check("busy", busy, rem > 0);
            check("done", done, rem == 1);
            check("md_stall", md_stall, D_is_md & (start | (rem > 0)));
            check("hilo", {hi, lo}, mon_hilo);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!hold_d) D_is_md = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        int unsigned lat;
        lat = op_latency(op);
        if (lat > 0 || op == 4 || op == 5) begin
            m_hilo = ref_model(op, a, b, m_hilo);
            exp_q.push_back(m_hilo);
        end
        start = 1'b1;
        md_op = MD_OP_W'(op);
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        if (lat > 0) begin
            repeat (lat) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 32'hFFFF_FFFE, 32'd3);
        check("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(1, 32'hFFFF_FFFE, 32'd3);
        check("multu_result", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        issue(2, 32'hFFFF_FFF9, 32'd2);
        check("div_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3, 32'h1234_5678, 32'd0);
        check("divu_by_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4, 32'h1234_5678, 32'h0);
        check("mthi", {hi, lo}, 64'h1234_5678_FFFF_FFFD);
        issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);

        D_is_md = 1'b1;
        issue(0, 32'd7, 32'd6);
        check("mflo_after_stall", lo, 32'd42);
        D_is_md = 1'b0;
        issue(2, 32'd100, 32'd7);

`ifdef MD_MADD_EN
        issue(4, 32'd0, 32'd0);
        issue(5, 32'd5, 32'd0);
        issue(6, 32'd2, 32'd3);
        check("madd_lo", {hi, lo}, 64'd11);
`endif

        hold_d = 1'b0;
        for (int i = 0; i < 150; i++) begin
            issue($urandom_range(0, OPMAX), rnd_val(), rnd_val());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        issue(0, 32'hDEAD_BEEF, 32'h0000_1234);
        start = 1'b1;
        md_op = MD_OP_W'(2);
        src_a = 32'd1000;
        src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        m_hilo = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_commit", {hi, lo}, 64'h0);

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, OPMAX), rnd_val(), rnd_val());
        end

        hold_d = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual=%0d required=0 pending results", exp_q.size());
        end
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
